// File: rtl/ccff_chain_loader_if.sv
// Bitstream-in / chain-control / readback-out bundle between a bitstream source
// and the loader that sits in front of a tile's configuration flop chain.
interface ccff_chain_loader_if #(
  parameter int WORD_W = 8
) ();
  logic              start;
  logic [WORD_W-1:0] cfg_data;
  logic              cfg_valid;
  logic              cfg_ready;
  logic              config_enable;
  logic              ccff_head;
  logic              ccff_tail;
  logic [WORD_W-1:0] tail_data;
  logic              tail_valid;
  logic              busy;
  logic              done;

  modport master (
    output start, cfg_data, cfg_valid, ccff_tail,
    input  cfg_ready, config_enable, ccff_head, tail_data, tail_valid, busy, done
  );

  modport slave (
    input  start, cfg_data, cfg_valid, ccff_tail,
    output cfg_ready, config_enable, ccff_head, tail_data, tail_valid, busy, done
  );
endinterface

// File: rtl/ccff_chain_loader.sv
// Shifts bitstream words LSB-first into a CCFF chain and packs the bits
// emerging at ccff_tail into readback words.
//   state     | meaning
//   S_IDLE    | after reset, nothing loaded
//   S_WAIT    | load in progress, chain paused, waiting for the next word
//   S_SHIFT   | config_enable high, one chain bit per prog_clock edge
//   S_DONE    | CHAIN_LEN bits shifted, holding until start or reset
module ccff_chain_loader #(
  parameter int WORD_W    = 8,
  parameter int CHAIN_LEN = 66
) (
  input  logic             prog_clock,
  input  logic             prog_reset,
  ccff_chain_loader_if.slave bus
);
  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
  localparam int WC_W  = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [WC_W-1:0]  WLAST = WC_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0] BLAST = CNT_W'(CHAIN_LEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SHIFT, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [WC_W-1:0]   wcnt_q, wcnt_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              cfg_en_q, cfg_en_d;
  logic              head_q, head_d;
  logic [WORD_W-1:0] pack_q, pack_d;
  logic [WC_W-1:0]   pcnt_q, pcnt_d;
  logic [WORD_W-1:0] tail_data_q, tail_data_d;
  logic              tail_valid_q, tail_valid_d;

  logic              cfg_ready;
  logic              accept;
  logic              word_end;
  logic              final_bit;
  logic [WORD_W-1:0] pack_cap;

  assign word_end  = (wcnt_q == WLAST);
  assign final_bit = (bit_cnt_q == BLAST);
  // Ready is offered one cycle early on a word boundary so words chain without a bubble.
  assign cfg_ready = (state_q == S_WAIT) ||
                     ((state_q == S_SHIFT) && word_end && !final_bit);
  assign accept    = bus.cfg_valid && cfg_ready;
  assign pack_cap  = pack_q | (WORD_W'(bus.ccff_tail) << pcnt_q);

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    wcnt_d       = wcnt_q;
    bit_cnt_d    = bit_cnt_q;
    cfg_en_d     = cfg_en_q;
    head_d       = head_q;
    pack_d       = pack_q;
    pcnt_d       = pcnt_q;
    tail_data_d  = tail_data_q;
    tail_valid_d = 1'b0;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d   = S_WAIT;
          bit_cnt_d = '0;
          pack_d    = '0;
          pcnt_d    = '0;
        end
      end
      S_WAIT: begin
        if (accept) begin
          state_d  = S_SHIFT;
          shreg_d  = bus.cfg_data;
          wcnt_d   = '0;
          head_d   = bus.cfg_data[0];
          cfg_en_d = 1'b1;
        end
      end
      S_SHIFT: begin
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
        wcnt_d    = wcnt_q + WC_W'(1);
        shreg_d   = shreg_q >> 1;
        head_d    = shreg_q[1];
        if ((pcnt_q == WLAST) || final_bit) begin
          tail_data_d  = pack_cap;
          tail_valid_d = 1'b1;
          pack_d       = '0;
          pcnt_d       = '0;
        end else begin
          pack_d = pack_cap;
          pcnt_d = pcnt_q + WC_W'(1);
        end
        // The final chain bit wins over a word boundary; leftover word bits are dropped.
        if (final_bit) begin
          state_d  = S_DONE;
          cfg_en_d = 1'b0;
          head_d   = head_q;
        end else if (word_end) begin
          if (accept) begin
            shreg_d = bus.cfg_data;
            wcnt_d  = '0;
            head_d  = bus.cfg_data[0];
          end else begin
            state_d  = S_WAIT;
            cfg_en_d = 1'b0;
            head_d   = head_q;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge prog_clock) begin
    if (prog_reset) begin
      state_q      <= S_IDLE;
      shreg_q      <= '0;
      wcnt_q       <= '0;
      bit_cnt_q    <= '0;
      cfg_en_q     <= 1'b0;
      head_q       <= 1'b0;
      pack_q       <= '0;
      pcnt_q       <= '0;
      tail_data_q  <= '0;
      tail_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      wcnt_q       <= wcnt_d;
      bit_cnt_q    <= bit_cnt_d;
      cfg_en_q     <= cfg_en_d;
      head_q       <= head_d;
      pack_q       <= pack_d;
      pcnt_q       <= pcnt_d;
      tail_data_q  <= tail_data_d;
      tail_valid_q <= tail_valid_d;
    end
  end

  assign bus.cfg_ready     = cfg_ready;
  assign bus.config_enable = cfg_en_q;
  assign bus.ccff_head     = head_q;
  assign bus.tail_data     = tail_data_q;
  assign bus.tail_valid    = tail_valid_q;
  assign bus.busy          = (state_q == S_WAIT) || (state_q == S_SHIFT);
  assign bus.done          = (state_q == S_DONE);
endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader: a bit-accurate chain model drives ccff_tail, and a
// stream-level model predicts head bits, handshakes and readback words each cycle.
module tb_ccff_chain_loader;
  localparam int WORD_W    = 8;
  localparam int CHAIN_LEN = 66;
  localparam int NWORDS    = (CHAIN_LEN + WORD_W - 1) / WORD_W;

  logic prog_clock = 1'b0;
  logic prog_reset = 1'b1;

  ccff_chain_loader_if #(.WORD_W(WORD_W)) bus ();

  ccff_chain_loader #(.WORD_W(WORD_W), .CHAIN_LEN(CHAIN_LEN)) dut (
    .prog_clock (prog_clock),
    .prog_reset (prog_reset),
    .bus        (bus.slave)
  );

  always #5 prog_clock = ~prog_clock;

  // Physical chain: chain[0] is the flop feeding ccff_tail.
  logic [CHAIN_LEN-1:0] chain = '0;
  logic                 preload_req = 1'b0;
  logic [CHAIN_LEN-1:0] preload_val = '0;
  always @(posedge prog_clock) begin
    if (preload_req)            chain <= preload_val;
    else if (bus.config_enable) chain <= {bus.ccff_head, chain[CHAIN_LEN-1:1]};
  end
  assign bus.ccff_tail = chain[0];

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: got timeout expected event", name);
  endtask

  // Stream-level model state.
  int                   phase = 0;  // 0 idle, 1 loading, 2 done
  int                   en_count = 0;
  int                   rd_idx = 0;
  int                   accepts = 0;
  int                   gaps = 0;
  int                   stall_at = -1;
  int                   done_rises = 0;
  int                   cyc = 0;
  int                   first_acc_cyc = -1;
  int                   done_cyc = -1;
  logic                 exp_tv = 1'b0;
  logic                 prev_done = 1'b0;
  logic [CHAIN_LEN-1:0] stream_bits = '0;
  logic [CHAIN_LEN-1:0] prev_chain = '0;
  logic [WORD_W-1:0]    rb [16];

  function automatic logic [WORD_W-1:0] exp_word(input int k);
    logic [WORD_W-1:0] r;
    r = '0;
    for (int b = 0; b < WORD_W; b++)
      if (k * WORD_W + b < CHAIN_LEN) r[b] = prev_chain[k * WORD_W + b];
    return r;
  endfunction

  always @(negedge prog_clock) begin : cmp
    logic er;
    cyc++;
    check("done", bus.done, phase == 2);
    check("busy", bus.busy, phase == 1);
    check("tail_valid", bus.tail_valid, exp_tv);
    if (bus.tail_valid) begin
      check("tail_data", bus.tail_data, exp_word(rd_idx));
      if (rd_idx < 16) rb[rd_idx] = bus.tail_data;
      rd_idx++;
    end
    if (phase != 1) check("config_enable_idle", bus.config_enable, 1'b0);
    er = (phase == 1) && (!bus.config_enable ||
          ((en_count % WORD_W == WORD_W - 1) && (en_count != CHAIN_LEN - 1)));
    check("cfg_ready", bus.cfg_ready, er);
    if (phase == 1 && bus.config_enable && en_count < CHAIN_LEN)
      check("ccff_head", bus.ccff_head, stream_bits[en_count]);
    else if (phase == 1 && en_count > 0)
      check("ccff_head_hold", bus.ccff_head, stream_bits[en_count-1]);
    if (bus.done && !prev_done) begin
      done_rises++;
      if (done_cyc < 0) done_cyc = cyc;
    end
    prev_done = bus.done;

    exp_tv = 1'b0;
    if (prog_reset) begin
      phase = 0;
      en_count = 0;
      rd_idx = 0;
    end else if (phase != 1) begin
      if (bus.start) begin
        phase = 1;
        en_count = 0;
        rd_idx = 0;
        accepts = 0;
        gaps = 0;
        stall_at = -1;
        done_rises = 0;
        first_acc_cyc = -1;
        done_cyc = -1;
        prev_chain = chain;
      end
    end else begin
      if (bus.cfg_valid && bus.cfg_ready) begin
        if (accepts == 0) first_acc_cyc = cyc;
        accepts++;
      end
      if (bus.config_enable) begin
        en_count++;
        if (en_count % WORD_W == 0 || en_count == CHAIN_LEN) exp_tv = 1'b1;
        if (en_count == CHAIN_LEN) phase = 2;
      end else begin
        gaps++;
        if (en_count > 0 && stall_at < 0) stall_at = en_count;
      end
    end
  end

  task automatic set_stream(input logic [WORD_W-1:0] w [NWORDS]);
    for (int i = 0; i < CHAIN_LEN; i++) stream_bits[i] = w[i / WORD_W][i % WORD_W];
  endtask

  task automatic run_load(input logic [WORD_W-1:0] w [NWORDS], input int stall_word,
                          input bit start_glitch, input int reset_bits, output bit aborted);
    bit acc;
    aborted = 1'b0;
    set_stream(w);
    bus.cfg_valid = 1'b0;
    @(posedge prog_clock); #1;
    bus.start = 1'b1;
    @(posedge prog_clock); #1;
    bus.start = 1'b0;
    for (int i = 0; i < NWORDS; i++) begin
      bus.cfg_data  = w[i];
      bus.cfg_valid = 1'b1;
      acc = 1'b0;
      for (int t = 0; t < 200 && !acc; t++) begin
        @(negedge prog_clock);
        if (bus.cfg_ready) acc = 1'b1;
        @(posedge prog_clock); #1;
        bus.start = 1'b0;
      end
      if (!acc) begin
        timeout_fail("accept_timeout");
        bus.cfg_valid = 1'b0;
        aborted = 1'b1;
        return;
      end
      if (start_glitch && i == 2) bus.start = 1'b1;
      if (i == stall_word) begin
        bus.cfg_valid = 1'b0;
        for (int t = 0; t < 100; t++) begin
          @(negedge prog_clock);
          if (!bus.config_enable) break;
        end
        @(posedge prog_clock);
        @(posedge prog_clock); #1;
      end
      if (reset_bits > 0 && i == 2) begin
        bus.cfg_valid = 1'b0;
        for (int t = 0; t < 100 && en_count < reset_bits; t++) begin
          @(posedge prog_clock); #1;
        end
        prog_reset = 1'b1;
        @(posedge prog_clock); #1;
        prog_reset = 1'b0;
        check("reset_mid_outputs",
              {bus.config_enable, bus.ccff_head, bus.cfg_ready, bus.tail_valid,
               bus.busy, bus.done, bus.tail_data}, '0);
        aborted = 1'b1;
        return;
      end
    end
    // Offer one surplus word; it must never be taken.
    bus.cfg_data  = 8'hAE;
    bus.cfg_valid = 1'b1;
    acc = 1'b0;
    for (int t = 0; t < 200 && !acc; t++) begin
      @(posedge prog_clock); #1;
      bus.start = 1'b0;
      if (bus.done) acc = 1'b1;
    end
    if (!acc) timeout_fail("done_timeout");
    repeat (3) @(posedge prog_clock);
    #1;
    bus.cfg_valid = 1'b0;
    check("chain_order", chain, stream_bits);
    check("words_accepted", accepts, NWORDS);
    check("done_once", done_rises, 1);
  endtask

  logic [WORD_W-1:0] wa [NWORDS];
  logic [WORD_W-1:0] p2 [NWORDS];
  logic [CHAIN_LEN-1:0] p1;
  bit ab;

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0;
    bus.cfg_valid = 1'b0;
    bus.cfg_data = '0;
    repeat (3) @(posedge prog_clock);
    #1;
    check("reset_outputs",
          {bus.config_enable, bus.ccff_head, bus.cfg_ready, bus.tail_valid,
           bus.busy, bus.done, bus.tail_data}, '0);
    prog_reset = 1'b0;

    // Continuous load 0xA5..0xAD.
    for (int i = 0; i < NWORDS; i++) wa[i] = 8'hA5 + 8'(i);
    run_load(wa, -1, 1'b0, 0, ab);
    check("lat_accept_to_done", done_cyc - first_acc_cyc, CHAIN_LEN + 1);
    check("lit_chain_low", chain[7:0], 8'hA5);
    check("lit_chain_top", {chain[65], chain[64]}, 2'b01);
    check("lit_gaps_cont", gaps, 1);

    // Readback: preload P1, load P2.
    p1 = 66'h3C3A59600FF12345C;
    preload_val = p1;
    @(posedge prog_clock); #1;
    preload_req = 1'b1;
    @(posedge prog_clock); #1;
    preload_req = 1'b0;
    for (int i = 0; i < NWORDS; i++) p2[i] = 8'h3C ^ 8'(i * 37);
    run_load(p2, -1, 1'b0, 0, ab);
    check("lit_rb_count", rd_idx, NWORDS);
    check("lit_rb_first", rb[0], 8'h5C);
    check("lit_rb_last", rb[NWORDS-1], 8'h03);

    // P3 reads back P2.
    for (int i = 0; i < NWORDS; i++) wa[i] = 8'hC3 - 8'(i * 11);
    run_load(wa, -1, 1'b0, 0, ab);
    check("lit_rb_p2_first", rb[0], p2[0]);
    check("lit_rb_p2_last", rb[NWORDS-1], {6'd0, p2[NWORDS-1][1:0]});

    // Stall after word 4.
    for (int i = 0; i < NWORDS; i++) wa[i] = 8'h5A ^ 8'(i * 29);
    run_load(wa, 3, 1'b0, 0, ab);
    check("lit_stall_bitcnt", stall_at, 32);
    check("lit_stall_gaps", gaps, 4);

    // Reset after 20 bits, then a full fresh load.
    for (int i = 0; i < NWORDS; i++) wa[i] = 8'h96 + 8'(i * 5);
    run_load(wa, -1, 1'b0, 20, ab);
    check("lit_reset_idle_busy", bus.busy, 1'b0);
    run_load(wa, -1, 1'b0, 0, ab);

    // start pulsed mid-shift is ignored.
    for (int i = 0; i < NWORDS; i++) wa[i] = 8'h0F + 8'(i * 17);
    run_load(wa, -1, 1'b1, 0, ab);
    check("lat_glitch", done_cyc - first_acc_cyc, CHAIN_LEN + 1);

    repeat (2) @(posedge prog_clock);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
